i2s_audio_out: RTL and testbench
================================

// Module: i2s_audio_out
//
// PURPOSE
// - Board-level sound output stage: consumes lab_top's 16-bit signed 'sound' and drives an external I2S DAC.
// - Pins: mclk, bclk, lrclk, sdata (mapped to LCD header pins).
// - Mono source: one accepted sample goes out on both left and right slots.
// - 1-deep input buffer with valid/ready handshake; repeats the last sample on underrun.
//
// PARAMETERS
// - clk_mhz        50  system clock, MHz (informational; rates below are clk divisions)
// - w_sample       16  sample width, two's complement
// - mclk_div       4   clk cycles per mclk period; even, >=2
// - bclk_per_mclk  4   mclk periods per bclk period; >=1
// - Defaults give bclk = 3.125 MHz and lrclk = 48.828 kHz.
//
// PORTS
// - clk          in   1         system clock
// - rst_n        in   1         asynchronous reset, active-low
// - data_in      in   w_sample  PCM sample, signed
// - data_valid   in   1         data_in is valid
// - data_ready   out  1         buffer empty; sample accepted when valid & ready
// - mclk         out  1         master clock = clk / mclk_div
// - bclk         out  1         bit clock, period B = mclk_div*bclk_per_mclk clk cycles
// - lrclk        out  1         word select: 0 = left, 1 = right
// - sdata        out  1         serial data, Philips I2S format
// - underrun     out  1         1-cycle pulse: frame started with buffer empty
//
// BEHAVIOUR
// - Reset (async, rst_n=0): all counters 0, frame register 0, buffer empty.
//   - Outputs: mclk=bclk=lrclk=sdata=0, data_ready=1, underrun=0.
//   - Reset mid-frame discards the buffered sample and the frame in progress.
// - Counters:
//   - clk_cnt counts 0..B-1. mclk = clk_cnt[log2(mclk_div)-1]; bclk = (clk_cnt >= B/2). Both are registered.
//   - bit_cnt (6 bits) counts 0..63 and advances when clk_cnt wraps B-1 -> 0 (bclk falling edge).
//   - lrclk = bit_cnt[5]; slot s = bit_cnt[4:0].
// - sdata, registered, updated in the same cycle as bit_cnt:
//   - s in 1..w_sample: frame[w_sample-s] (MSB first, one bclk after lrclk changes).
//   - s = 0 or s > w_sample: 0.
//   - DAC samples on bclk rising edge, mid-bit.
// - Frame start (bit_cnt wraps 63 -> 0, the left slot begins):
//   - Buffer full: frame <= buffer; buffer empties; data_ready=1 on the next cycle.
//   - Buffer empty: frame keeps its previous value; underrun=1 for exactly that cycle.
// - Handshake:
//   - data_ready = !buffer_full.
//   - Accept on data_valid & data_ready; data_ready=0 from the next cycle.
//   - Accept and frame start in the same cycle with the buffer empty: the sample goes into the buffer, underrun still pulses, and the frame repeats.
//   - data_valid while ready=0 is ignored; the source must hold its data.
// - Latency: an accepted sample's MSB appears on sdata at bit_cnt=1 of the next frame start. Worst case one frame plus 2*B clk cycles.
// - Width: frame holds w_sample bits; no sign extension; slot padding is zeros.
//
// STRUCTURE
// - Package i2s_pkg holds:
//   - localparam slot_bits = 32 and frame_bits = 64.
//   - typedef enum logic {CH_LEFT=0, CH_RIGHT=1} i2s_ch_t.
// - Sub-module i2s_clock_gen holds clk_cnt and bit_cnt.
//   - Outputs: mclk, bclk, lrclk, bit_cnt, strobes bclk_fall and frame_start.
// - Top level holds the buffer, the frame register, the sdata mux and underrun.
//
// TESTING
// - Reset: rst_n=0 mid-frame -> same cycle mclk=bclk=lrclk=sdata=0, data_ready=1; after release, first bclk rise at clk 8.
// - Clocks (defaults): mclk period 4 clk; bclk period 16 clk; lrclk period 1024 clk with 50% duty; lrclk edges coincide with bclk falls.
// - Sample 16'hA5C3 accepted -> next frame: left and right slots both carry A5C3, MSB first, in slots 1..16; slots 0 and 17..31 are 0.
// - No further data -> next frame: underrun pulses once at frame start; A5C3 repeats on both channels.
// - Back-to-back: 16'h8000 accepted, then 16'h7FFF offered -> data_ready stays 0 until frame start; 8000 plays, then 7FFF plays.
// - Accept in the same cycle as frame start with the buffer empty -> underrun=1; old frame repeats; new sample plays in the following frame.

Source files
------------

// File: rtl/i2s_pkg.sv
// Shared constants and types for the I2S audio output stage.
// A frame is two 32-bit slots, left first.
package i2s_pkg;

    localparam int slot_bits  = 32;
    localparam int frame_bits = 64;

    typedef enum logic {CH_LEFT = 1'b0, CH_RIGHT = 1'b1} i2s_ch_t;

    // Sample bits occupy slots 1..w; slot 0 is the one-bit I2S delay, the rest is padding.
    function automatic logic slot_active(input logic [4:0] slot, input int w);
        return (slot != 5'd0) && (int'(slot) <= w);
    endfunction

endpackage

// File: rtl/i2s_clock_gen.sv
// I2S clock generator: derives mclk, bclk and lrclk from clk by division.
// It also produces the strobes that the top level uses to shift out data.
module i2s_clock_gen
    import i2s_pkg::*;
#(
    parameter int mclk_div      = 4,
    parameter int bclk_per_mclk = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    output logic                          mclk,
    output logic                          bclk,
    output logic                          lrclk,
    output logic [$clog2(frame_bits)-1:0] bit_cnt,
    output logic                          bclk_fall,
    output logic                          frame_start
);

    localparam int b_period = mclk_div * bclk_per_mclk;
    localparam int cw       = $clog2(b_period);
    localparam int bw       = $clog2(frame_bits);
    localparam int mclk_bit = $clog2(mclk_div) - 1;

    logic [cw-1:0] clk_cnt_q, clk_cnt_d;
    logic [bw-1:0] bit_cnt_q, bit_cnt_d;
    logic          mclk_q, mclk_d;
    logic          bclk_q, bclk_d;
    i2s_ch_t       ch;

    // Strobes are high in the last cycle before the edge where the counters wrap.
    always_comb begin
        bclk_fall   = (clk_cnt_q == cw'(b_period - 1));
        frame_start = bclk_fall && (bit_cnt_q == bw'(frame_bits - 1));
        clk_cnt_d   = bclk_fall ? '0 : clk_cnt_q + cw'(1);
        bit_cnt_d   = bclk_fall ? bit_cnt_q + bw'(1) : bit_cnt_q;
        mclk_d      = clk_cnt_d[mclk_bit];
        bclk_d      = (clk_cnt_d >= cw'(b_period / 2));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clk_cnt_q <= '0;
            bit_cnt_q <= '0;
            mclk_q    <= 1'b0;
            bclk_q    <= 1'b0;
        end else begin
            clk_cnt_q <= clk_cnt_d;
            bit_cnt_q <= bit_cnt_d;
            mclk_q    <= mclk_d;
            bclk_q    <= bclk_d;
        end
    end

    assign ch      = i2s_ch_t'(bit_cnt_q[bw-1]);
    assign lrclk   = (ch == CH_RIGHT);
    assign mclk    = mclk_q;
    assign bclk    = bclk_q;
    assign bit_cnt = bit_cnt_q;

endmodule

// File: rtl/i2s_audio_out.sv
// Mono PCM to Philips I2S transmitter with a one-sample input buffer.
// The sample is sent on both channels; an empty buffer at frame start repeats the last frame.
module i2s_audio_out
    import i2s_pkg::*;
#(
    parameter int clk_mhz       = 50,
    parameter int w_sample      = 16,
    parameter int mclk_div      = 4,
    parameter int bclk_per_mclk = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [w_sample-1:0] data_in,
    input  logic                data_valid,
    output logic                data_ready,
    output logic                mclk,
    output logic                bclk,
    output logic                lrclk,
    output logic                sdata,
    output logic                underrun
);

    localparam int bw = $clog2(frame_bits);
    localparam int iw = (w_sample > 1) ? $clog2(w_sample) : 1;

    logic [bw-1:0]       bit_cnt;
    logic [bw-1:0]       bit_next;
    logic                bclk_fall;
    logic                frame_start;
    logic                accept;
    logic [4:0]          slot;
    logic [iw-1:0]       idx;

    logic [w_sample-1:0] buf_q, buf_d;
    logic                buf_full_q, buf_full_d;
    logic [w_sample-1:0] frame_q, frame_d;
    logic                sdata_q, sdata_d;
    logic                underrun_q, underrun_d;

    i2s_clock_gen #(
        .mclk_div      (mclk_div),
        .bclk_per_mclk (bclk_per_mclk)
    ) u_clock_gen (
        .clk         (clk),
        .rst_n       (rst_n),
        .mclk        (mclk),
        .bclk        (bclk),
        .lrclk       (lrclk),
        .bit_cnt     (bit_cnt),
        .bclk_fall   (bclk_fall),
        .frame_start (frame_start)
    );

    always_comb begin
        accept     = data_valid && !buf_full_q;
        buf_d      = buf_q;
        buf_full_d = buf_full_q;
        frame_d    = frame_q;
        underrun_d = 1'b0;

        // A sample accepted on the frame-start cycle waits for the following frame.
        if (frame_start && buf_full_q) begin
            frame_d    = buf_q;
            buf_full_d = 1'b0;
        end else begin
            if (frame_start) begin
                underrun_d = 1'b1;
            end
            if (accept) begin
                buf_d      = data_in;
                buf_full_d = 1'b1;
            end
        end
    end

    // sdata changes together with bit_cnt, so select using the slot about to start.
    always_comb begin
        bit_next = bit_cnt + bw'(1);
        slot     = bit_next[4:0];
        idx      = iw'(w_sample - int'(slot));
        sdata_d  = sdata_q;
        if (bclk_fall) begin
            sdata_d = slot_active(slot, w_sample) ? frame_q[idx] : 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            buf_q      <= '0;
            buf_full_q <= 1'b0;
            frame_q    <= '0;
            sdata_q    <= 1'b0;
            underrun_q <= 1'b0;
        end else begin
            buf_q      <= buf_d;
            buf_full_q <= buf_full_d;
            frame_q    <= frame_d;
            sdata_q    <= sdata_d;
            underrun_q <= underrun_d;
        end
    end

    assign data_ready = !buf_full_q;
    assign sdata      = sdata_q;
    assign underrun   = underrun_q;

endmodule

// File: tb/tb_i2s_audio_out.sv
// Directed bench for i2s_audio_out at default parameters (B = 16 clk, frame = 1024 clk).
// t counts clk rising edges since the last reset release; checks happen 1 time unit after an edge.
module tb_i2s_audio_out;

    logic        clk;
    logic        rst_n;
    logic [15:0] data_in;
    logic        data_valid;
    logic        data_ready;
    logic        mclk;
    logic        bclk;
    logic        lrclk;
    logic        sdata;
    logic        underrun;

    int checks = 0;
    int errors = 0;
    int t      = 0;

    i2s_audio_out dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .data_in    (data_in),
        .data_valid (data_valid),
        .data_ready (data_ready),
        .mclk       (mclk),
        .bclk       (bclk),
        .lrclk      (lrclk),
        .sdata      (sdata),
        .underrun   (underrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h (t=%0d)", tag, obs, exp, t);
        end
    endtask

    task automatic goto(input int target);
        while (t < target) begin
            @(posedge clk);
            #1;
            t++;
        end
    endtask

    task automatic chk_reset_outputs();
        chk("rst mclk", {31'd0, mclk}, 32'd0);
        chk("rst bclk", {31'd0, bclk}, 32'd0);
        chk("rst lrclk", {31'd0, lrclk}, 32'd0);
        chk("rst sdata", {31'd0, sdata}, 32'd0);
        chk("rst data_ready", {31'd0, data_ready}, 32'd1);
        chk("rst underrun", {31'd0, underrun}, 32'd0);
    endtask

    // Clock shapes and the first (empty-buffer) frame start after a release.
    task automatic release_checks();
        int rise;
        rise = 0;
        goto(2);
        chk("mclk t2", {31'd0, mclk}, 32'd1);
        goto(4);
        chk("mclk t4", {31'd0, mclk}, 32'd0);
        while (t < 20) begin
            goto(t + 1);
            if (bclk === 1'b1 && rise == 0) rise = t;
        end
        chk("first bclk rise", rise, 32'd8);
        goto(24);
        chk("bclk t24", {31'd0, bclk}, 32'd1);
        goto(32);
        chk("bclk t32", {31'd0, bclk}, 32'd0);
        goto(511);
        chk("lrclk t511", {31'd0, lrclk}, 32'd0);
        goto(512);
        chk("lrclk t512", {31'd0, lrclk}, 32'd1);
        goto(1023);
        chk("lrclk t1023", {31'd0, lrclk}, 32'd1);
        chk("underrun t1023", {31'd0, underrun}, 32'd0);
        goto(1024);
        chk("lrclk t1024", {31'd0, lrclk}, 32'd0);
        chk("underrun first frame", {31'd0, underrun}, 32'd1);
        goto(1025);
        chk("underrun pulse width", {31'd0, underrun}, 32'd0);
        goto(1048);
        chk("sdata empty frame slot1", {31'd0, sdata}, 32'd0);
        chk("ready after release", {31'd0, data_ready}, 32'd1);
    endtask

    // Every slot of both channels, sampled at the bclk rising edge (mid-bit).
    task automatic check_frame(input int base, input logic [15:0] pat);
        logic e;
        for (int ch = 0; ch < 2; ch++) begin
            for (int s = 0; s < 32; s++) begin
                goto(base + ch * 512 + s * 16 + 8);
                if (s == 0) chk($sformatf("lrclk ch%0d", ch), {31'd0, lrclk}, ch);
                e = (s >= 1 && s <= 16) ? pat[16 - s] : 1'b0;
                chk($sformatf("sdata %h ch%0d slot%0d", pat, ch, s), {31'd0, sdata}, {31'd0, e});
            end
        end
    endtask

    initial begin
        rst_n      = 1'b0;
        data_in    = 16'h0000;
        data_valid = 1'b0;
        #1;
        chk_reset_outputs();
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        t     = 0;
        release_checks();

        // Single sample A5C3
        goto(1050);
        chk("ready before A5C3", {31'd0, data_ready}, 32'd1);
        data_in    = 16'hA5C3;
        data_valid = 1'b1;
        goto(1051);
        data_valid = 1'b0;
        chk("ready after A5C3", {31'd0, data_ready}, 32'd0);
        goto(2047);
        chk("ready held full", {31'd0, data_ready}, 32'd0);
        goto(2048);
        chk("underrun A5C3 frame", {31'd0, underrun}, 32'd0);
        chk("ready after load", {31'd0, data_ready}, 32'd1);
        check_frame(2048, 16'hA5C3);

        // No new data: repeat with underrun
        goto(3072);
        chk("underrun repeat", {31'd0, underrun}, 32'd1);
        goto(3073);
        chk("underrun repeat end", {31'd0, underrun}, 32'd0);
        check_frame(3072, 16'hA5C3);

        // Back-to-back 8000 then 7FFF
        goto(4090);
        chk("ready before 8000", {31'd0, data_ready}, 32'd1);
        data_in    = 16'h8000;
        data_valid = 1'b1;
        goto(4091);
        chk("ready after 8000", {31'd0, data_ready}, 32'd0);
        data_in = 16'h7FFF;
        goto(4095);
        chk("ready blocked 7FFF", {31'd0, data_ready}, 32'd0);
        goto(4096);
        chk("ready at frame start", {31'd0, data_ready}, 32'd1);
        chk("underrun 8000 frame", {31'd0, underrun}, 32'd0);
        goto(4097);
        chk("ready after 7FFF", {31'd0, data_ready}, 32'd0);
        data_valid = 1'b0;
        check_frame(4096, 16'h8000);
        goto(5120);
        chk("underrun 7FFF frame", {31'd0, underrun}, 32'd0);
        check_frame(5120, 16'h7FFF);

        // Accept on the frame-start cycle with an empty buffer
        goto(6143);
        chk("ready before 1234", {31'd0, data_ready}, 32'd1);
        data_in    = 16'h1234;
        data_valid = 1'b1;
        goto(6144);
        data_valid = 1'b0;
        chk("underrun same-cycle", {31'd0, underrun}, 32'd1);
        chk("ready same-cycle", {31'd0, data_ready}, 32'd0);
        check_frame(6144, 16'h7FFF);
        goto(7168);
        chk("underrun 1234 frame", {31'd0, underrun}, 32'd0);
        chk("ready 1234 frame", {31'd0, data_ready}, 32'd1);
        check_frame(7168, 16'h1234);
        goto(8192);
        chk("underrun before reset", {31'd0, underrun}, 32'd1);

        // Fill the buffer, then reset mid-frame
        goto(8200);
        data_in    = 16'hBEEF;
        data_valid = 1'b1;
        goto(8201);
        data_valid = 1'b0;
        chk("ready BEEF held", {31'd0, data_ready}, 32'd0);
        goto(8778);
        chk("pre-reset lrclk", {31'd0, lrclk}, 32'd1);
        chk("pre-reset bclk", {31'd0, bclk}, 32'd1);
        chk("pre-reset mclk", {31'd0, mclk}, 32'd1);
        chk("pre-reset sdata", {31'd0, sdata}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk_reset_outputs();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        t     = 0;
        release_checks();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
